// File: rtl/sram256x8_arb_ctrl.sv
// -----------------------------------------------------------------------------
// sram256x8_arb_ctrl
//
// Arbitrated two-requester controller for the 256x8 single-port SRAM macro
// (gf180mcu_fd_ip_sram__sram256x8m8wm1).
//
// After reset the block optionally clears every word to INIT_VALUE, then
// shares the macro between requesters A and B with round-robin arbitration.
// Every access goes through a registered command stage, so the macro pins are
// driven only by flops. Read data comes back on a fixed 3-cycle, fully
// pipelined path tagged with the requester that issued the read.
//
// Handshake: a requester raises i_x_req with its fields and holds them stable;
// o_x_gnt is combinational and the transfer completes in the cycle where
// i_x_req and o_x_gnt are both high. The requester may change fields or drop
// the request on the following cycle.
//
// Parameters
//   INIT_EN     1 = clear all 256 words after reset, 0 = skip the clear
//   INIT_VALUE  word written everywhere during the clear
//
// Ports
//   i_clk, i_rst                clock (rising edge), synchronous active-high reset
//   o_busy                      clear in progress, no grants while high
//   o_dbg_state                 FSM state (0 = INIT, 1 = RUN)
//   i_a_req / i_b_req           access request
//   i_a_we / i_b_we             1 = write, 0 = read
//   i_a_addr / i_b_addr         word address
//   i_a_wdata / i_b_wdata       write data
//   i_a_wmask / i_b_wmask       per-bit write enable, 1 = write the bit
//   o_a_gnt / o_b_gnt           combinational grant
//   o_a_rvalid / o_b_rvalid     one-cycle read-data-valid pulse
//   o_a_rdata / o_b_rdata       registered read data, holds between pulses
//   o_sram_cen                  macro chip enable, active-low
//   o_sram_gwen                 macro global write enable, active-low
//   o_sram_wen                  macro per-bit write enable, active-low
//   o_sram_a / o_sram_d         macro address / write data
//   i_sram_q                    macro read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module sram256x8_arb_ctrl #(
  parameter bit         INIT_EN    = 1'b1,
  parameter logic [7:0] INIT_VALUE = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_busy,
  output logic       o_dbg_state,

  input  logic       i_a_req,
  input  logic       i_a_we,
  input  logic [7:0] i_a_addr,
  input  logic [7:0] i_a_wdata,
  input  logic [7:0] i_a_wmask,
  output logic       o_a_gnt,
  output logic       o_a_rvalid,
  output logic [7:0] o_a_rdata,

  input  logic       i_b_req,
  input  logic       i_b_we,
  input  logic [7:0] i_b_addr,
  input  logic [7:0] i_b_wdata,
  input  logic [7:0] i_b_wmask,
  output logic       o_b_gnt,
  output logic       o_b_rvalid,
  output logic [7:0] o_b_rdata,

  output logic       o_sram_cen,
  output logic       o_sram_gwen,
  output logic [7:0] o_sram_wen,
  output logic [7:0] o_sram_a,
  output logic [7:0] o_sram_d,
  input  logic [7:0] i_sram_q
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_busy;

  logic [7:0] r_init_cnt;

  // Round-robin pointer: 1 means B was granted last, so A wins the next tie.
  logic       r_last_b;
  logic       w_run;
  logic       w_a_gnt;
  logic       w_b_gnt;

  // Command stage (registered macro pins)
  logic       r_sram_cen;
  logic       r_sram_gwen;
  logic [7:0] r_sram_wen;
  logic [7:0] r_sram_a;
  logic [7:0] r_sram_d;

  logic       w_cmd_cen;
  logic       w_cmd_gwen;
  logic [7:0] w_cmd_wen;
  logic [7:0] w_cmd_a;
  logic [7:0] w_cmd_d;
  logic       w_cmd_rd;
  logic       w_cmd_id;

  // Read return pipeline: stage 0 aligns with the command on the pins,
  // stage 1 aligns with i_sram_q being valid.
  logic       r_rd_v0;
  logic       r_rd_id0;
  logic       r_rd_v1;
  logic       r_rd_id1;

  logic       r_a_rvalid;
  logic       r_b_rvalid;
  logic [7:0] r_a_rdata;
  logic [7:0] r_b_rdata;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= INIT_EN ? ST_INIT : ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state and outputs
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_busy = 1'b1;
        // The last clear write is loaded into the command stage this cycle.
        if (r_init_cnt == 8'hFF) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // Clear address counter; wraps back to 0 as the FSM leaves INIT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_init_cnt <= 8'h00;
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + 8'h01;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // Grants are masked by reset directly so that nothing is granted in a reset
  // cycle even though the state register has not been updated yet.
  assign w_run   = (r_state == ST_RUN) && !i_rst;
  assign w_a_gnt = w_run && i_a_req && (!i_b_req || r_last_b);
  assign w_b_gnt = w_run && i_b_req && (!i_a_req || !r_last_b);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_b <= 1'b1;
    end else if (w_a_gnt) begin
      r_last_b <= 1'b0;
    end else if (w_b_gnt) begin
      r_last_b <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Command selection
  // ---------------------------------------------------------------------------
  // Idle cycles deassert the enables but keep address and data, so the pins
  // only toggle when a real access is issued.
  always_comb begin
    w_cmd_cen  = 1'b1;
    w_cmd_gwen = 1'b1;
    w_cmd_wen  = 8'hFF;
    w_cmd_a    = r_sram_a;
    w_cmd_d    = r_sram_d;
    w_cmd_rd   = 1'b0;
    w_cmd_id   = 1'b0;
    if (w_busy) begin
      w_cmd_cen  = 1'b0;
      w_cmd_gwen = 1'b0;
      w_cmd_wen  = 8'h00;
      w_cmd_a    = r_init_cnt;
      w_cmd_d    = INIT_VALUE;
    end else if (w_a_gnt) begin
      w_cmd_cen = 1'b0;
      w_cmd_a   = i_a_addr;
      if (i_a_we) begin
        w_cmd_gwen = 1'b0;
        w_cmd_wen  = ~i_a_wmask;
        w_cmd_d    = i_a_wdata;
      end else begin
        w_cmd_rd = 1'b1;
        w_cmd_id = 1'b0;
      end
    end else if (w_b_gnt) begin
      w_cmd_cen = 1'b0;
      w_cmd_a   = i_b_addr;
      if (i_b_we) begin
        w_cmd_gwen = 1'b0;
        w_cmd_wen  = ~i_b_wmask;
        w_cmd_d    = i_b_wdata;
      end else begin
        w_cmd_rd = 1'b1;
        w_cmd_id = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sram_cen  <= 1'b1;
      r_sram_gwen <= 1'b1;
      r_sram_wen  <= 8'hFF;
      r_sram_a    <= 8'h00;
      r_sram_d    <= 8'h00;
    end else begin
      r_sram_cen  <= w_cmd_cen;
      r_sram_gwen <= w_cmd_gwen;
      r_sram_wen  <= w_cmd_wen;
      r_sram_a    <= w_cmd_a;
      r_sram_d    <= w_cmd_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return path
  // ---------------------------------------------------------------------------
  // Reset clears every valid bit, so reads in flight at reset never return.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_v0    <= 1'b0;
      r_rd_id0   <= 1'b0;
      r_rd_v1    <= 1'b0;
      r_rd_id1   <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= 8'h00;
      r_b_rdata  <= 8'h00;
    end else begin
      r_rd_v0    <= w_cmd_rd;
      r_rd_id0   <= w_cmd_id;
      r_rd_v1    <= r_rd_v0;
      r_rd_id1   <= r_rd_id0;
      r_a_rvalid <= r_rd_v1 && !r_rd_id1;
      r_b_rvalid <= r_rd_v1 && r_rd_id1;
      if (r_rd_v1 && !r_rd_id1) begin
        r_a_rdata <= i_sram_q;
      end
      if (r_rd_v1 && r_rd_id1) begin
        r_b_rdata <= i_sram_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_busy      = w_busy;
  assign o_dbg_state = r_state;
  assign o_a_gnt     = w_a_gnt;
  assign o_b_gnt     = w_b_gnt;
  assign o_a_rvalid  = r_a_rvalid;
  assign o_b_rvalid  = r_b_rvalid;
  assign o_a_rdata   = r_a_rdata;
  assign o_b_rdata   = r_b_rdata;
  assign o_sram_cen  = r_sram_cen;
  assign o_sram_gwen = r_sram_gwen;
  assign o_sram_wen  = r_sram_wen;
  assign o_sram_a    = r_sram_a;
  assign o_sram_d    = r_sram_d;

endmodule

// File: tb/tb_sram256x8_arb_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for sram256x8_arb_ctrl.
// A behavioural SRAM macro sits on the pins. The reference model tracks the
// memory contents as a plain array, the arbiter as "who went last", the read
// returns as a queue of {due cycle, requester, data}, and the expected macro
// pins from the access rules.
// -----------------------------------------------------------------------------
module tb_sram256x8_arb_ctrl;

  localparam logic [7:0] INIT_VAL = 8'hA5;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, a_wmask, b_addr, b_wdata, b_wmask;
  logic       busy, dbg_state;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       sram_cen, sram_gwen;
  logic [7:0] sram_wen, sram_a, sram_d, sram_q;

  sram256x8_arb_ctrl #(
    .INIT_EN    (1'b1),
    .INIT_VALUE (INIT_VAL)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .o_busy      (busy),
    .o_dbg_state (dbg_state),
    .i_a_req     (a_req),
    .i_a_we      (a_we),
    .i_a_addr    (a_addr),
    .i_a_wdata   (a_wdata),
    .i_a_wmask   (a_wmask),
    .o_a_gnt     (a_gnt),
    .o_a_rvalid  (a_rvalid),
    .o_a_rdata   (a_rdata),
    .i_b_req     (b_req),
    .i_b_we      (b_we),
    .i_b_addr    (b_addr),
    .i_b_wdata   (b_wdata),
    .i_b_wmask   (b_wmask),
    .o_b_gnt     (b_gnt),
    .o_b_rvalid  (b_rvalid),
    .o_b_rdata   (b_rdata),
    .o_sram_cen  (sram_cen),
    .o_sram_gwen (sram_gwen),
    .o_sram_wen  (sram_wen),
    .o_sram_a    (sram_a),
    .o_sram_d    (sram_d),
    .i_sram_q    (sram_q)
  );

  // Behavioural macro: samples on the rising edge, read data valid next cycle.
  logic [7:0] sram_mem [256];
  always @(posedge clk) begin
    if (sram_cen === 1'b0) begin
      if (sram_gwen === 1'b0) begin
        sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      end else begin
        sram_q <= sram_mem[sram_a];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  bit          m_last_b;
  logic [7:0]  ref_mem [256];
  logic [40:0] exp_q[$];  // {due cycle, requester (1 = B), data}
  logic [7:0]  exp_ra, exp_rb;
  logic        pc_cen, pc_gwen;
  logic [7:0]  pc_wen, pc_a, pc_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic apply_access(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                              input logic [7:0] wmask, input bit id);
    pc_cen = 1'b0;
    pc_a   = addr;
    if (we) begin
      pc_gwen = 1'b0;
      pc_wen  = ~wmask;
      pc_d    = wdata;
      ref_mem[addr] = (ref_mem[addr] & ~wmask) | (wdata & wmask);
    end else begin
      pc_gwen = 1'b1;
      pc_wen  = 8'hFF;
      exp_q.push_back({32'(cyc + 3), id, ref_mem[addr]});
    end
  endtask

  // One clock cycle with the currently driven inputs, checked at the falling edge.
  task automatic tick(output bit hs_a, output bit hs_b, output logic dg_a, output logic dg_b);
    bit         busy_e, ea, eb, va, vb, qid;
    logic [7:0] qd;
    logic [40:0] ent;
    @(negedge clk);
    busy_e = (cyc < 256);
    ea = !busy_e && a_req && (!b_req || m_last_b);
    eb = !busy_e && b_req && (!a_req || !m_last_b);
    dg_a = a_gnt;
    dg_b = b_gnt;
    chk("busy", busy, busy_e);
    chk("a_gnt", a_gnt, ea);
    chk("b_gnt", b_gnt, eb);
    chk("pin_cen", sram_cen, pc_cen);
    chk("pin_gwen", sram_gwen, pc_gwen);
    chk("pin_wen", sram_wen, pc_wen);
    chk("pin_a", sram_a, pc_a);
    chk("pin_d", sram_d, pc_d);
    va = 1'b0;
    vb = 1'b0;
    if (exp_q.size() > 0) begin
      ent = exp_q[0];
      if (ent[40:9] == 32'(cyc)) begin
        ent = exp_q.pop_front();
        qid = ent[8];
        qd  = ent[7:0];
        if (qid) begin vb = 1'b1; exp_rb = qd; end
        else     begin va = 1'b1; exp_ra = qd; end
      end
    end
    chk("a_rvalid", a_rvalid, va);
    chk("b_rvalid", b_rvalid, vb);
    chk("a_rdata", a_rdata, exp_ra);
    chk("b_rdata", b_rdata, exp_rb);
    if (busy_e) begin
      pc_cen = 1'b0; pc_gwen = 1'b0; pc_wen = 8'h00; pc_a = 8'(cyc); pc_d = INIT_VAL;
    end else if (ea) begin
      apply_access(a_we, a_addr, a_wdata, a_wmask, 1'b0);
    end else if (eb) begin
      apply_access(b_we, b_addr, b_wdata, b_wmask, 1'b1);
    end else begin
      pc_cen = 1'b1; pc_gwen = 1'b1; pc_wen = 8'hFF;
    end
    if (ea) m_last_b = 1'b0;
    else if (eb) m_last_b = 1'b1;
    hs_a = ea;
    hs_b = eb;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("rst_a_gnt", a_gnt, 1'b0);
      chk("rst_b_gnt", b_gnt, 1'b0);
      if (k > 0) begin
        chk("rst_busy", busy, 1'b1);
        chk("rst_cen", sram_cen, 1'b1);
        chk("rst_gwen", sram_gwen, 1'b1);
        chk("rst_wen", sram_wen, 8'hFF);
        chk("rst_a", sram_a, 8'h00);
        chk("rst_d", sram_d, 8'h00);
        chk("rst_a_rvalid", a_rvalid, 1'b0);
        chk("rst_b_rvalid", b_rvalid, 1'b0);
        chk("rst_a_rdata", a_rdata, 8'h00);
        chk("rst_b_rdata", b_rdata, 8'h00);
      end
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    cyc = 0;
    m_last_b = 1'b1;
    exp_q.delete();
    foreach (ref_mem[i]) ref_mem[i] = INIT_VAL;
    exp_ra = 8'h00; exp_rb = 8'h00;
    pc_cen = 1'b1; pc_gwen = 1'b1; pc_wen = 8'hFF; pc_a = 8'h00; pc_d = 8'h00;
  endtask

  task automatic idle(input int n);
    bit ha, hb;
    logic ga, gb;
    a_req = 1'b0;
    b_req = 1'b0;
    for (int k = 0; k < n; k++) tick(ha, hb, ga, gb);
  endtask

  task automatic do_access(input bit port, input logic we, input logic [7:0] addr,
                           input logic [7:0] wdata, input logic [7:0] wmask);
    bit ha, hb, done;
    logic ga, gb;
    if (port) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; b_wmask = wmask;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; a_wmask = wmask;
    end
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      tick(ha, hb, ga, gb);
      if (port ? hb : ha) done = 1'b1;
    end
    a_req = 1'b0;
    b_req = 1'b0;
    if (!done) chk("access_timeout", 32'd0, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       a_req, a_we;
    logic [7:0] a_addr, a_wdata, a_wmask;
    logic       b_req, b_we;
    logic [7:0] b_addr, b_wdata, b_wmask;
    logic       exp_a, exp_b;
  } vec_t;

  function automatic vec_t mk(input logic ar, input logic aw, input logic [7:0] aa,
                              input logic [7:0] ad, input logic [7:0] am,
                              input logic br, input logic bw, input logic [7:0] ba,
                              input logic [7:0] bd, input logic [7:0] bm,
                              input logic ea, input logic eb);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad; v.a_wmask = am;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd; v.b_wmask = bm;
    v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  vec_t tbl [17];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    bit ha, hb, got_a, got_b;
    logic ga, gb;
    int c0;

    // Entering the table the last grant went to A (single read of 8'hFF).
    tbl[0]  = mk(Y, Y, 8'h10, 8'h3C, 8'hFF,  N, N, 8'h00, 8'h00, 8'h00,  Y, N); // A write 3C
    tbl[1]  = mk(Y, N, 8'h10, 8'h00, 8'h00,  N, N, 8'h00, 8'h00, 8'h00,  Y, N); // A read -> 3C
    tbl[2]  = mk(N, N, 8'h00, 8'h00, 8'h00,  Y, Y, 8'h20, 8'hFF, 8'hFF,  N, Y); // B fill FF
    tbl[3]  = mk(N, N, 8'h00, 8'h00, 8'h00,  N, N, 8'h00, 8'h00, 8'h00,  N, N);
    tbl[4]  = mk(N, N, 8'h00, 8'h00, 8'h00,  Y, Y, 8'h20, 8'h00, 8'h0F,  N, Y); // wen F0
    tbl[5]  = mk(N, N, 8'h00, 8'h00, 8'h00,  Y, N, 8'h20, 8'h00, 8'h00,  N, Y); // -> F0
    tbl[6]  = mk(Y, Y, 8'h05, 8'h77, 8'hFF,  N, N, 8'h00, 8'h00, 8'h00,  Y, N); // A write 77
    tbl[7]  = mk(N, N, 8'h00, 8'h00, 8'h00,  Y, N, 8'h05, 8'h00, 8'h00,  N, Y); // B RAW -> 77
    for (int i = 8; i < 14; i++) begin
      tbl[i] = mk(Y, N, 8'h10, 8'h00, 8'h00,  Y, N, 8'h20, 8'h00, 8'h00,
                  (i % 2 == 0) ? Y : N, (i % 2 == 0) ? N : Y);
    end
    tbl[14] = mk(N, N, 8'h00, 8'h00, 8'h00,  N, N, 8'h00, 8'h00, 8'h00,  N, N);
    tbl[15] = mk(Y, Y, 8'h30, 8'h55, 8'h00,  N, N, 8'h00, 8'h00, 8'h00,  Y, N); // mask 0
    tbl[16] = mk(Y, N, 8'h30, 8'h00, 8'h00,  N, N, 8'h00, 8'h00, 8'h00,  Y, N); // -> A5

    // Requests are held through reset and init; nothing may be granted early.
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h00; a_wmask = 8'h00;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h80; b_wdata = 8'h00; b_wmask = 8'h00;
    rst = 1'b1;
    do_reset(3);

    got_a = 1'b0;
    got_b = 1'b0;
    for (int k = 0; k < 400 && !(got_a && got_b); k++) begin
      c0 = cyc;
      tick(ha, hb, ga, gb);
      if (ha) begin
        a_req = 1'b0;
        got_a = 1'b1;
        chk("first_grant_cycle", 32'(c0), 32'd256);
      end
      if (hb) begin
        b_req = 1'b0;
        got_b = 1'b1;
      end
    end
    if (!(got_a && got_b)) chk("init_grant_timeout", 32'd0, 32'd1);
    do_access(1'b0, 1'b0, 8'hFF, 8'h00, 8'h00);
    idle(6);

    for (int i = 0; i < 17; i++) begin
      a_req = tbl[i].a_req; a_we = tbl[i].a_we; a_addr = tbl[i].a_addr;
      a_wdata = tbl[i].a_wdata; a_wmask = tbl[i].a_wmask;
      b_req = tbl[i].b_req; b_we = tbl[i].b_we; b_addr = tbl[i].b_addr;
      b_wdata = tbl[i].b_wdata; b_wmask = tbl[i].b_wmask;
      tick(ha, hb, ga, gb);
      chk("tbl_a_gnt", ga, tbl[i].exp_a);
      chk("tbl_b_gnt", gb, tbl[i].exp_b);
    end
    idle(6);

    // Random traffic; each requester holds its fields until granted.
    for (int k = 0; k < 300; k++) begin
      if (!a_req && $urandom_range(0, 2) != 0) begin
        a_req = 1'b1; a_we = 1'($urandom_range(0, 1)); a_addr = 8'($urandom_range(0, 15));
        a_wdata = 8'($urandom); a_wmask = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      end
      if (!b_req && $urandom_range(0, 2) != 0) begin
        b_req = 1'b1; b_we = 1'($urandom_range(0, 1)); b_addr = 8'($urandom_range(0, 15));
        b_wdata = 8'($urandom); b_wmask = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      end
      tick(ha, hb, ga, gb);
      if (ha) a_req = 1'b0;
      if (hb) b_req = 1'b0;
    end
    idle(6);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-read: A reads at N, RST at N+1. The read must never return,
    // init restarts at address 0 and A's held request waits for init to end.
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h20;
    b_req = 1'b0;
    tick(ha, hb, ga, gb);
    chk("midrst_read_hs", ha, 1'b1);
    a_addr = 8'h10;
    do_reset(1);
    got_a = 1'b0;
    for (int k = 0; k < 400 && !got_a; k++) begin
      tick(ha, hb, ga, gb);
      if (ha) begin
        a_req = 1'b0;
        got_a = 1'b1;
      end
    end
    if (!got_a) chk("midrst_grant_timeout", 32'd0, 32'd1);
    idle(6);
    chk("queue_drained_end", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
